// File: rtl/mux_tree_pipe_pkg.sv
// rtl/mux_tree_pipe_pkg.sv - shared sizing helpers for the pipelined mux tree
// Purpose: tree geometry helpers used by mux_tree_pipe and its testbench.
//   All levels of the tree live back to back in one flat word bus:
//   level 0 is the N input words, level k is the output of stage k-1,
//   and the last level is the single selected word.
// Ports: none (package).
package mux_tree_pipe_pkg;

  // Number of tree inputs, N = 2**log2n.
  function automatic int unsigned tree_inputs(input int unsigned log2n);
    return 32'd1 << log2n;
  endfunction

  // Number of words held by stage k (the output of the k-th halving step).
  function automatic int unsigned stage_words(input int unsigned log2n, input int unsigned k);
    return (32'd1 << log2n) >> (k + 32'd1);
  endfunction

  // Word offset of level k in the flat level bus.
  // The levels have sizes N, N/2, ..., 1, so level k starts at 2N - 2*(N>>k).
  function automatic int unsigned level_offset(input int unsigned log2n, input int unsigned k);
    return (32'd2 << log2n) - (((32'd1 << log2n) >> k) << 1);
  endfunction

endpackage

// File: rtl/mux_tree_pipe_mux2_stage.sv
// rtl/mux_tree_pipe_mux2_stage.sv - one registered halving level of the mux tree
// Purpose: selects between each adjacent word pair of a WORDS_IN*W bus with
//   one select bit and registers the WORDS_IN/2 result words plus a valid bit.
//   The register loads only when en_i is high; otherwise everything holds.
// Ports:
//   clk      in   1                   rising-edge clock
//   reset    in   1                   synchronous active-high reset
//   en_i     in   1                   load enable (pipeline advance)
//   valid_i  in   1                   valid bit travelling with data_i
//   sel_i    in   1                   picks odd (1) or even (0) word of each pair
//   data_i   in   WORDS_IN*W          input words, word i at [i*W +: W]
//   valid_o  out  1                   registered valid
//   data_o   out  (WORDS_IN/2)*W      registered result words
module mux2_stage #(
  parameter int W        = 8,
  parameter int WORDS_IN = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en_i,
  input  logic                        valid_i,
  input  logic                        sel_i,
  input  logic [WORDS_IN*W-1:0]       data_i,
  output logic                        valid_o,
  output logic [(WORDS_IN/2)*W-1:0]   data_o
);

  localparam int WORDS_OUT = WORDS_IN / 2;

  logic [WORDS_OUT*W-1:0] data_d;
  logic [WORDS_OUT*W-1:0] data_q;
  logic                   valid_q;

  // Pure per-pair select: an unselected word never reaches the result,
  // so X on unused inputs cannot leak through once sel_i is known.
  always_comb begin
    data_d = '0;
    for (int j = 0; j < WORDS_OUT; j++) begin
      data_d[j*W +: W] = sel_i ? data_i[(2*j+1)*W +: W] : data_i[(2*j)*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (en_i) begin
      valid_q <= valid_i;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/mux_tree_pipe.sv
// rtl/mux_tree_pipe.sv - pipelined N:1 word multiplexer tree with valid/ready
// Purpose: forwards word in_sel of the N = 2**LOG2N input words after LOG2N
//   register stages. Stage k resolves select bit k (LSB first). The whole
//   pipe advances together whenever the output slot is empty or consumed.
// Ports:
//   clk        in   1        rising-edge clock
//   reset      in   1        synchronous active-high reset
//   in_valid   in   1        in_data/in_sel offered
//   in_ready   out  1        input accepted this cycle
//   in_sel     in   LOG2N    index of the word to forward
//   in_data    in   N*W      word i at in_data[i*W +: W]
//   out_valid  out  1        out_data/out_sel hold a result
//   out_ready  in   1        downstream consumes the result
//   out_data   out  W        selected word
//   out_sel    out  LOG2N    in_sel that produced out_data
module mux_tree_pipe
  import mux_tree_pipe_pkg::*;
#(
  parameter int W     = 8,
  parameter int LOG2N = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [LOG2N-1:0]                in_sel,
  input  logic [(W << LOG2N)-1:0]         in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [W-1:0]                    out_data,
  output logic [LOG2N-1:0]                out_sel
);

  localparam int N           = int'(tree_inputs(LOG2N));
  localparam int TOTAL_WORDS = 2 * N - 1;

  // Every tree level, input included, packed back to back.
  logic [TOTAL_WORDS*W-1:0] lvl_data;
  logic                     lvl_valid [LOG2N+1];

  // Full original select carried alongside each stage; stage k still needs
  // bits [LOG2N-1:k+1] and the last copy becomes out_sel.
  logic [LOG2N-1:0]         sel_q [LOG2N];

  logic                     adv;

  // A single advance for the whole pipe: no bubble squeezing.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  assign lvl_data[0 +: N*W] = in_data;
  assign lvl_valid[0]       = in_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < LOG2N; k++) begin
        sel_q[k] <= '0;
      end
    end else if (adv) begin
      sel_q[0] <= in_sel;
      for (int k = 1; k < LOG2N; k++) begin
        sel_q[k] <= sel_q[k-1];
      end
    end
  end

  for (genvar k = 0; k < LOG2N; k++) begin : g_stage
    localparam int WORDS_IN = N >> k;
    localparam int IN_OFF   = int'(level_offset(LOG2N, k)) * W;
    localparam int OUT_OFF  = int'(level_offset(LOG2N, k + 1)) * W;

    logic stage_sel;

    // Stage 0 resolves bit 0 straight from the input; later stages take
    // their bit from the select registered by the previous stage.
    if (k == 0) begin : g_first
      assign stage_sel = in_sel[0];
    end else begin : g_later
      assign stage_sel = sel_q[k-1][k];
    end

    mux2_stage #(
      .W        (W),
      .WORDS_IN (WORDS_IN)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .en_i    (adv),
      .valid_i (lvl_valid[k]),
      .sel_i   (stage_sel),
      .data_i  (lvl_data[IN_OFF +: WORDS_IN*W]),
      .valid_o (lvl_valid[k+1]),
      .data_o  (lvl_data[OUT_OFF +: (WORDS_IN/2)*W])
    );
  end

  assign out_valid = lvl_valid[LOG2N];
  assign out_data  = lvl_data[(TOTAL_WORDS-1)*W +: W];
  assign out_sel   = sel_q[LOG2N-1];

endmodule
